// File: rtl/flt_seq_pkg.sv
// Shared types and constants for the float-add job sequencer.
package flt_seq_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned HALF_W = 16;
   localparam int unsigned CNT_W  = 16;

   localparam logic [HALF_W-1:0] NAN16   = 16'h7E00;
   localparam logic [CNT_W-1:0]  CYC_MAX = 16'hFFFF;

   localparam logic [ADDR_W-1:0] OP_BASE_DEF  = 8'd8;
   localparam logic [ADDR_W-1:0] RES_BASE_DEF = 8'd12;
   localparam int unsigned       TIMEOUT_DEF  = 2048;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CRST,
      ST_WR0,
      ST_WR1,
      ST_WR2,
      ST_WR3,
      ST_GO,
      ST_WAIT,
      ST_RD0,
      ST_RD1,
      ST_OUT
   } state_t;

endpackage

// File: rtl/sat_cycle_counter.sv
// Saturating 16-bit cycle counter with a flag when the count equals TIMEOUT-1.
module sat_cycle_counter
   import flt_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             hit
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != CYC_MAX)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign hit   = (32'(count_q) == (TIMEOUT - 32'd1));

endmodule

// File: rtl/flt_job_sequencer.sv
// Job sequencer for the float-add core: loads operands, starts the core,
// waits for done (with timeout) and returns the 16-bit result plus cycle count.
module flt_job_sequencer
   import flt_seq_pkg::*;
#(
   parameter logic [ADDR_W-1:0] OP_BASE  = OP_BASE_DEF,
   parameter logic [ADDR_W-1:0] RES_BASE = RES_BASE_DEF,
   parameter int unsigned       TIMEOUT  = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [HALF_W-1:0] in_a,
   input  logic [HALF_W-1:0] in_b,
   output logic              core_rst,
   output logic              start,
   input  logic              done,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [HALF_W-1:0] out_result,
   output logic [CNT_W-1:0]  out_cycles,
   output logic              out_timeout
);

   state_t            state_q;
   logic [HALF_W-1:0] a_q;
   logic [HALF_W-1:0] b_q;
   logic [HALF_W-1:0] result_q;
   logic [CNT_W-1:0]  cycles_q;
   logic              timeout_q;
   logic              in_ready_q;
   logic              core_rst_q;
   logic              start_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              out_valid_q;

   logic [CNT_W-1:0]  wait_cnt;
   logic              wait_hit;

   // Counter is held at zero outside WAIT so the first WAIT cycle reads 0.
   sat_cycle_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (state_q != ST_WAIT),
      .en    (state_q == ST_WAIT),
      .count (wait_cnt),
      .hit   (wait_hit)
   );

   // Each strobe/bus register is loaded on entry to the state that owns it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         cycles_q    <= '0;
         timeout_q   <= 1'b0;
         in_ready_q  <= 1'b0;
         core_rst_q  <= 1'b0;
         start_q     <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         in_ready_q  <= 1'b0;
         core_rst_q  <= 1'b0;
         start_q     <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         case (state_q)
            ST_IDLE: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  a_q        <= in_a;
                  b_q        <= in_b;
                  timeout_q  <= 1'b0;
                  in_ready_q <= 1'b0;
                  core_rst_q <= 1'b1;
                  state_q    <= ST_CRST;
               end
            end
            ST_CRST: begin
               mem_we_q    <= 1'b1;
               mem_addr_q  <= OP_BASE;
               mem_wdata_q <= a_q[7:0];
               state_q     <= ST_WR0;
            end
            ST_WR0: begin
               mem_we_q    <= 1'b1;
               mem_addr_q  <= OP_BASE + ADDR_W'(1);
               mem_wdata_q <= a_q[15:8];
               state_q     <= ST_WR1;
            end
            ST_WR1: begin
               mem_we_q    <= 1'b1;
               mem_addr_q  <= OP_BASE + ADDR_W'(2);
               mem_wdata_q <= b_q[7:0];
               state_q     <= ST_WR2;
            end
            ST_WR2: begin
               mem_we_q    <= 1'b1;
               mem_addr_q  <= OP_BASE + ADDR_W'(3);
               mem_wdata_q <= b_q[15:8];
               state_q     <= ST_WR3;
            end
            ST_WR3: begin
               start_q <= 1'b1;
               state_q <= ST_GO;
            end
            ST_GO: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               // done takes priority over a simultaneous timeout
               if (done) begin
                  cycles_q   <= wait_cnt;
                  mem_addr_q <= RES_BASE;
                  state_q    <= ST_RD0;
               end else if (wait_hit) begin
                  cycles_q    <= wait_cnt;
                  timeout_q   <= 1'b1;
                  result_q    <= NAN16;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_OUT;
               end
            end
            ST_RD0: begin
               result_q[7:0] <= mem_rdata;
               mem_addr_q    <= RES_BASE + ADDR_W'(1);
               state_q       <= ST_RD1;
            end
            ST_RD1: begin
               result_q[15:8] <= mem_rdata;
               out_valid_q    <= 1'b1;
               state_q        <= ST_OUT;
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign core_rst    = core_rst_q;
   assign start       = start_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign out_valid   = out_valid_q;
   assign out_result  = result_q;
   assign out_cycles  = cycles_q;
   assign out_timeout = timeout_q;

endmodule

// File: tb/tb_flt_job_sequencer.sv
// Directed bench for flt_job_sequencer with a stub float-add core and data memory.
module tb_flt_job_sequencer;

   localparam logic [7:0] RES = 8'd12;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        core_rst;
   logic        start;
   logic        done_r = 1'b0;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [15:0] out_cycles;
   logic        out_timeout;

   int checks = 0;
   int errors = 0;

   flt_job_sequencer #(
      .OP_BASE  (8'd8),
      .RES_BASE (8'd12),
      .TIMEOUT  (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .core_rst    (core_rst),
      .start       (start),
      .done        (done_r),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_cycles  (out_cycles),
      .out_timeout (out_timeout)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [256] = '{default: 8'h00};
   assign mem_rdata = mem[mem_addr];

   int          cyc = 0;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          acc_cnt = 0;
   int          hs_cnt = 0;
   logic [7:0]  wlog_addr [256];
   logic [7:0]  wlog_data [256];
   int          acc_cyc [16];
   int          hs_cyc [16];
   logic [15:0] hs_res [16];

   int          core_dly = 5;
   bit          core_never = 1'b0;
   bit          stale_hold = 1'b0;
   logic [15:0] core_res = 16'h0000;
   int          remain = 0;
   bit          busy = 1'b0;

   // Memory, bus monitor and stub core: done rises so that it is seen in WAIT cycle core_dly.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wlog_addr[wr_cnt % 256] <= mem_addr;
         wlog_data[wr_cnt % 256] <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end else if (mem_addr != 8'd0) begin
         rd_cnt <= rd_cnt + 1;
      end
      if (in_valid && in_ready) begin
         acc_cyc[acc_cnt % 16] <= cyc;
         acc_cnt <= acc_cnt + 1;
      end
      if (out_valid && out_ready) begin
         hs_cyc[hs_cnt % 16] <= cyc;
         hs_res[hs_cnt % 16] <= out_result;
         hs_cnt <= hs_cnt + 1;
      end
      if (start) begin
         done_r <= 1'b0;
         remain <= core_dly;
         busy   <= !core_never && (core_dly != 0);
         if (!core_never && (core_dly == 0)) begin
            done_r        <= 1'b1;
            mem[RES]      <= core_res[7:0];
            mem[RES + 1]  <= core_res[15:8];
         end
      end else if (core_rst && !stale_hold) begin
         busy   <= 1'b0;
         done_r <= 1'b0;
      end else if (busy) begin
         remain <= remain - 1;
         if (remain == 1) begin
            busy         <= 1'b0;
            done_r       <= 1'b1;
            mem[RES]     <= core_res[7:0];
            mem[RES + 1] <= core_res[15:8];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One full job; exp_cyc < 0 skips the cycle-count check, hold = cycles of back-pressure.
   task automatic run_job(input logic [15:0] a, input logic [15:0] b, input int dly,
                          input bit never, input logic [15:0] core_val,
                          input logic [15:0] exp_res, input int exp_cyc,
                          input bit exp_to, input int hold);
      int k;
      core_dly   = dly;
      core_never = never;
      core_res   = core_val;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("accept_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      @(negedge clk);
      in_valid = 1'b0;
      chk("crst_pulse", 32'(core_rst), 32'd1);
      k = 1;
      while (!start && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("start_latency", 32'(k), 32'd6);
      @(negedge clk);
      chk("start_single", 32'(start), 32'd0);
      k = 0;
      while (!out_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("out_valid_seen", 32'(out_valid), 32'd1);
      chk("out_result", 32'(out_result), 32'(exp_res));
      if (exp_cyc >= 0) chk("out_cycles", 32'(out_cycles), 32'(exp_cyc));
      chk("out_timeout", 32'(out_timeout), 32'(exp_to));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_result", 32'(out_result), 32'(exp_res));
         chk("bp_timeout", 32'(out_timeout), 32'(exp_to));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("handoff_valid", 32'(out_valid), 32'd0);
      chk("handoff_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      int k;
      int wb;
      int rb;
      int ab;
      int hb;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_a      = 16'h0000;
      in_b      = 16'h0000;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_core_rst", 32'(core_rst), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_timeout", 32'(out_timeout), 32'd0);
      chk("rst_out_result", 32'(out_result), 32'd0);
      chk("rst_out_cycles", 32'(out_cycles), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Basic job with the operand write pattern
      wb = wr_cnt;
      rb = rd_cnt;
      run_job(16'h1A04, 16'h1A04, 5, 1'b0, 16'h1E04, 16'h1E04, 5, 1'b0, 0);
      chk("basic_writes", 32'(wr_cnt - wb), 32'd4);
      chk("basic_reads", 32'(rd_cnt - rb), 32'd2);
      chk("wr0_addr", 32'(wlog_addr[wb]), 32'd8);
      chk("wr0_data", 32'(wlog_data[wb]), 32'h04);
      chk("wr1_addr", 32'(wlog_addr[wb + 1]), 32'd9);
      chk("wr1_data", 32'(wlog_data[wb + 1]), 32'h1A);
      chk("wr2_addr", 32'(wlog_addr[wb + 2]), 32'd10);
      chk("wr2_data", 32'(wlog_data[wb + 2]), 32'h04);
      chk("wr3_addr", 32'(wlog_addr[wb + 3]), 32'd11);
      chk("wr3_data", 32'(wlog_data[wb + 3]), 32'h1A);

      // Back-pressure for 10 cycles
      run_job(16'h3C00, 16'h3C00, 2, 1'b0, 16'h4000, 16'h4000, 2, 1'b0, 10);

      // Stale done: core keeps done high until it sees start
      chk("stale_done_high", 32'(done_r), 32'd1);
      stale_hold = 1'b1;
      run_job(16'h3C00, 16'h4000, 3, 1'b0, 16'h4200, 16'h4200, 3, 1'b0, 0);
      stale_hold = 1'b0;

      // Timeout: no done ever, no result reads
      rb = rd_cnt;
      run_job(16'h1111, 16'h2222, 0, 1'b1, 16'h0000, 16'h7E00, -1, 1'b1, 0);
      chk("timeout_no_reads", 32'(rd_cnt - rb), 32'd0);

      // done on the last allowed WAIT cycle wins over timeout
      run_job(16'h4400, 16'h4400, 15, 1'b0, 16'h4800, 16'h4800, 15, 1'b0, 0);

      // Reset during WR2
      core_dly   = 5;
      core_never = 1'b0;
      in_valid   = 1'b1;
      in_a       = 16'h1234;
      in_b       = 16'h5678;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!(mem_we && mem_addr == 8'd10) && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("mid_wr2_reached", 32'(mem_addr), 32'd10);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
      chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("mid_rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("mid_rst_start", 32'(start), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_result", 32'(out_result), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_idle", 32'(in_ready), 32'd1);
      run_job(16'h4204, 16'h4004, 4, 1'b0, 16'h4504, 16'h4504, 4, 1'b0, 0);

      // Back-to-back jobs with in_valid held high
      ab = acc_cnt;
      wb = wr_cnt;
      rb = rd_cnt;
      hb = hs_cnt;
      core_dly   = 2;
      core_never = 1'b0;
      core_res   = 16'h4000;
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      in_a       = 16'h3C00;
      in_b       = 16'h3C00;
      k = 0;
      while (acc_cnt < ab + 1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      in_a = 16'h4000;
      in_b = 16'h4000;
      k = 0;
      while (hs_cnt < hb + 1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      core_res = 16'h4400;
      k = 0;
      while (acc_cnt < ab + 2 && k < 50) begin
         @(negedge clk);
         k++;
      end
      in_valid = 1'b0;
      k = 0;
      while (hs_cnt < hb + 2 && k < 100) begin
         @(negedge clk);
         k++;
      end
      out_ready = 1'b0;
      @(negedge clk);
      chk("b2b_accepts", 32'(acc_cnt - ab), 32'd2);
      chk("b2b_handoffs", 32'(hs_cnt - hb), 32'd2);
      chk("b2b_writes", 32'(wr_cnt - wb), 32'd8);
      chk("b2b_reads", 32'(rd_cnt - rb), 32'd4);
      chk("b2b_accept_after_handoff", 32'(acc_cyc[(ab + 1) % 16] > hs_cyc[hb % 16]), 32'd1);
      chk("b2b_result0", 32'(hs_res[hb % 16]), 32'h4000);
      chk("b2b_result1", 32'(hs_res[(hb + 1) % 16]), 32'h4400);
      chk("b2b_idle", 32'(in_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
